// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD command-line response receiver.
package sd_pkg;

    localparam logic [6:0] CRC7_POLY   = 7'h09;
    localparam int         SHORT_BITS  = 48;
    localparam int         LONG_BITS   = 136;
    localparam int         NCR_MAX_DEF = 64;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECV       = 2'd2,
        DONE       = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sd_cmd_resp_rx_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB-first.
module crc7_serial
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[6] ^ din;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// Receives one SD command response (48-bit or 136-bit R2) from the CMD line,
// checks CRC7, end bit and direction bit, and reports a Ncr timeout.
module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX    = sd_pkg::NCR_MAX_DEF,
    parameter int LONG_BITS  = sd_pkg::LONG_BITS,
    parameter int SHORT_BITS = sd_pkg::SHORT_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_en,
    input  logic         cmd_in,
    input  logic         start,
    input  logic         resp_long,
    input  logic         crc_skip,
    output logic         busy,
    output logic         done,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [119:0] resp_r2,
    output logic         crc_err,
    output logic         end_err,
    output logic         dir_err,
    output logic         timeout,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(LONG_BITS);
    localparam int WW = $clog2(NCR_MAX + 1);
    localparam logic [CW-1:0] LAST_SHORT = CW'(SHORT_BITS - 1);
    localparam logic [CW-1:0] LAST_LONG  = CW'(LONG_BITS - 1);
    localparam logic [CW-1:0] CRC_END_S  = CW'(SHORT_BITS - 9);
    localparam logic [CW-1:0] CRC_BEG_L  = CW'(8);
    localparam logic [CW-1:0] CRC_END_L  = CW'(LONG_BITS - 9);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(NCR_MAX - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [LONG_BITS-1:0] shift_q, shift_d, shift_in;
    logic                 long_q, long_d;
    logic                 skip_q, skip_d;
    logic [5:0]           resp_index_q, resp_index_d;
    logic [31:0]          resp_arg_q, resp_arg_d;
    logic [119:0]         resp_r2_q, resp_r2_d;
    logic                 crc_err_q, crc_err_d;
    logic                 end_err_q, end_err_d;
    logic                 dir_err_q, dir_err_d;
    logic                 timeout_q, timeout_d;
    logic                 crc_clr, crc_en;
    logic [6:0]           crc_val;
    logic [6:0]           crc_rx;

    crc7_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (cmd_in),
        .crc (crc_val)
    );

    // Frame as it will look once the current cmd_in bit is shifted in.
    assign shift_in = {shift_q[LONG_BITS-2:0], cmd_in};
    assign crc_rx   = shift_in[7:1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        shift_d      = shift_q;
        long_d       = long_q;
        skip_d       = skip_q;
        resp_index_d = resp_index_q;
        resp_arg_d   = resp_arg_q;
        resp_r2_d    = resp_r2_q;
        crc_err_d    = crc_err_q;
        end_err_d    = end_err_q;
        dir_err_d    = dir_err_q;
        timeout_d    = timeout_q;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_START;
                    long_d     = resp_long;
                    skip_d     = crc_skip;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    shift_d    = '0;
                    crc_clr    = 1'b1;
                    crc_err_d  = 1'b0;
                    end_err_d  = 1'b0;
                    dir_err_d  = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            WAIT_START: begin
                if (bit_en) begin
                    if (!cmd_in) begin
                        // The start bit is frame bit 0 and is CRC-covered only in short frames.
                        state_d   = RECV;
                        shift_d   = shift_in;
                        bit_cnt_d = CW'(1);
                        crc_en    = !long_q;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                        if (wait_cnt_q == WAIT_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
            end
            RECV: begin
                if (bit_en) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    crc_en    = long_q ? (bit_cnt_q >= CRC_BEG_L && bit_cnt_q <= CRC_END_L)
                                       : (bit_cnt_q <= CRC_END_S);
                    if (long_q ? (bit_cnt_q == LAST_LONG) : (bit_cnt_q == LAST_SHORT)) begin
                        state_d   = DONE;
                        end_err_d = !shift_in[0];
                        crc_err_d = (crc_val != crc_rx) && !skip_q;
                        if (long_q) begin
                            dir_err_d = shift_in[LONG_BITS-2];
                            resp_r2_d = shift_in[LONG_BITS-9:8];
                        end else begin
                            dir_err_d    = shift_in[SHORT_BITS-2];
                            resp_index_d = shift_in[SHORT_BITS-3:SHORT_BITS-8];
                            resp_arg_d   = shift_in[39:8];
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            shift_q      <= '0;
            long_q       <= 1'b0;
            skip_q       <= 1'b0;
            resp_index_q <= '0;
            resp_arg_q   <= '0;
            resp_r2_q    <= '0;
            crc_err_q    <= 1'b0;
            end_err_q    <= 1'b0;
            dir_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            shift_q      <= shift_d;
            long_q       <= long_d;
            skip_q       <= skip_d;
            resp_index_q <= resp_index_d;
            resp_arg_q   <= resp_arg_d;
            resp_r2_q    <= resp_r2_d;
            crc_err_q    <= crc_err_d;
            end_err_q    <= end_err_d;
            dir_err_q    <= dir_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy       = (state_q == WAIT_START) || (state_q == RECV);
    assign done       = (state_q == DONE);
    assign resp_index = resp_index_q;
    assign resp_arg   = resp_arg_q;
    assign resp_r2    = resp_r2_q;
    assign crc_err    = crc_err_q;
    assign end_err    = end_err_q;
    assign dir_err    = dir_err_q;
    assign timeout    = timeout_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Bench for sd_cmd_resp_rx: vector table of response frames plus timeout,
// reset-abort and start-collision sequences, checked through an expected queue.
module tb_sd_cmd_resp_rx;

    localparam int EW = 6 + 32 + 120 + 4;

    logic         clk = 1'b0;
    logic         rst, bit_en, cmd_in, start, resp_long, crc_skip;
    logic         busy, done, crc_err, end_err, dir_err, timeout;
    logic [5:0]   resp_index;
    logic [31:0]  resp_arg;
    logic [119:0] resp_r2;
    logic [1:0]   state_dbg;

    sd_cmd_resp_rx dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .cmd_in     (cmd_in),
        .start      (start),
        .resp_long  (resp_long),
        .crc_skip   (crc_skip),
        .busy       (busy),
        .done       (done),
        .resp_index (resp_index),
        .resp_arg   (resp_arg),
        .resp_r2    (resp_r2),
        .crc_err    (crc_err),
        .end_err    (end_err),
        .dir_err    (dir_err),
        .timeout    (timeout),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [135:0] frame;
        logic         long_f;
        logic         skip;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [119:0] r2;
        logic [3:0]   flags;  // {crc_err, end_err, dir_err, timeout}
    } vec_t;

    vec_t         tbl[10];
    logic [EW-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_seen = 0;
    int           done_exp = 0;
    logic [5:0]   m_idx;
    logic [31:0]  m_arg;
    logic [119:0] m_r2;
    logic [119:0] pay_a, pay_b;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_calc(input logic [119:0] d);
        logic [6:0] c = '0;
        logic       f;
        for (int i = 119; i >= 0; i--) begin
            f = c[6] ^ d[i];
            c = {c[5:0], 1'b0};
            if (f) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Scoreboard: every done pulse consumes one expected record.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", EW'(1), EW'(0));
            end else begin
                e = exp_q.pop_front();
                check("resp_index", EW'(resp_index), EW'(e[EW-1 -: 6]));
                check("resp_arg",   EW'(resp_arg),   EW'(e[EW-7 -: 32]));
                check("resp_r2",    EW'(resp_r2),    EW'(e[123:4]));
                check("flags",      EW'({crc_err, end_err, dir_err, timeout}), EW'(e[3:0]));
                check("busy_at_done", EW'(busy), EW'(0));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        cmd_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        cmd_in = 1'b1;
        tick();
        tick();
    endtask

    task automatic push_exp(input logic [3:0] flags);
        exp_q.push_back({m_idx, m_arg, m_r2, flags});
        done_exp++;
    endtask

    task automatic arm(input logic lng, input logic skip);
        start     = 1'b1;
        resp_long = lng;
        crc_skip  = skip;
        tick();
        start     = 1'b0;
        check("busy_after_start", EW'(busy), EW'(1));
        // A second start while busy, with opposite options, must be ignored.
        start     = 1'b1;
        resp_long = ~lng;
        crc_skip  = ~skip;
        tick();
        start     = 1'b0;
        resp_long = 1'b0;
        crc_skip  = 1'b0;
    endtask

    task automatic run_frame(input logic [135:0] f, input logic lng, input logic skip,
                             input logic start_in_done);
        int nb = lng ? 136 : 48;
        arm(lng, skip);
        repeat ($urandom_range(0, 5)) send_bit(1'b1);
        for (int i = nb - 1; i >= 1; i--) send_bit(f[i]);
        cmd_in = f[0];
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        cmd_in = 1'b1;
        check("done_latency", EW'(done), EW'(1));
        if (start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", EW'(done), EW'(0));
        if (start_in_done) check("start_in_done_ignored", EW'(busy), EW'(0));
    endtask

    initial begin
        rst = 1'b1; bit_en = 1'b0; cmd_in = 1'b1; start = 1'b0;
        resp_long = 1'b0; crc_skip = 1'b0;
        m_idx = '0; m_arg = '0; m_r2 = '0;
        pay_a = {$urandom, $urandom, $urandom, $urandom};
        pay_b = {$urandom, $urandom, $urandom, $urandom};

        tbl[0] = '{136'h37_00000120_83, 1'b0, 1'b0, 6'h37, 32'h00000120, '0, 4'b0000};
        tbl[1] = '{136'h08_000001AA_13, 1'b0, 1'b0, 6'h08, 32'h000001AA, '0, 4'b0000};
        tbl[2] = '{136'h08_000001AA_15, 1'b0, 1'b0, 6'h08, 32'h000001AA, '0, 4'b1000};
        tbl[3] = '{136'h3F_00FF8000_FF, 1'b0, 1'b1, 6'h3F, 32'h00FF8000, '0, 4'b0000};
        tbl[4] = '{136'h3F_00FF8000_FF, 1'b0, 1'b0, 6'h3F, 32'h00FF8000, '0, 4'b1000};
        tbl[5] = '{136'h77_00000120_83, 1'b0, 1'b0, 6'h37, 32'h00000120, '0, 4'b1010};
        tbl[6] = '{136'h37_00000120_82, 1'b0, 1'b0, 6'h37, 32'h00000120, '0, 4'b0100};
        tbl[7] = '{{8'h3F, pay_a, crc7_calc(pay_a), 1'b1}, 1'b1, 1'b0, '0, '0, pay_a, 4'b0000};
        tbl[8] = '{{8'h3F, pay_a, crc7_calc(pay_a), 1'b0}, 1'b1, 1'b0, '0, '0, pay_a, 4'b0100};
        tbl[9] = '{{8'h3F, pay_b, crc7_calc(pay_b) ^ 7'h01, 1'b1}, 1'b1, 1'b0, '0, '0, pay_b, 4'b1000};

        repeat (3) tick();
        check("reset_busy",   EW'(busy), EW'(0));
        check("reset_done",   EW'(done), EW'(0));
        check("reset_fields", EW'({resp_index, resp_arg, resp_r2}), EW'(0));
        check("reset_flags",  EW'({crc_err, end_err, dir_err, timeout}), EW'(0));
        rst = 1'b0;
        tick();

        // Strobes with cmd_in low while idle must not start a frame.
        repeat (3) send_bit(1'b0);
        check("idle_ignores_bit_en", EW'({busy, state_dbg}), EW'(0));

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].long_f) m_r2 = tbl[i].r2;
            else begin
                m_idx = tbl[i].idx;
                m_arg = tbl[i].arg;
            end
            push_exp(tbl[i].flags);
            run_frame(tbl[i].frame, tbl[i].long_f, tbl[i].skip, i == 0);
        end

        // Ncr timeout: 64 high strobes, payload outputs keep their last values.
        push_exp(4'b0001);
        arm(1'b0, 1'b0);
        for (int i = 0; i < 63; i++) send_bit(1'b1);
        check("no_early_timeout", EW'(done), EW'(0));
        cmd_in = 1'b1;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        check("timeout_latency", EW'(done), EW'(1));
        tick();

        // Reset at frame bit 20 aborts with no done and clears everything.
        arm(1'b0, 1'b0);
        for (int i = 47; i > 27; i--) send_bit(tbl[1].frame[i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", EW'({busy, done, resp_index, resp_arg, resp_r2}), EW'(0));
        check("abort_flags",   EW'({crc_err, end_err, dir_err, timeout}), EW'(0));
        m_idx = '0; m_arg = '0; m_r2 = '0;

        m_idx = 6'h08;
        m_arg = 32'h000001AA;
        push_exp(4'b0000);
        run_frame(tbl[1].frame, 1'b0, 1'b0, 1'b0);

        repeat (4) tick();
        check("done_count", EW'(done_seen), EW'(done_exp));
        check("queue_drained", EW'(exp_q.size()), EW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1);
    end

endmodule
